mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, data-memory word-address width (1024 x 64-bit words).
REQ-002 Parameter DATA_W, default 64, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MAX_WAIT, default 4, maximum consecutive cycles debug may be refused before it gets forced priority.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 c_req  in  1  core MEM-stage access request.
REQ-007 c_we  in  1  core write (1) or read (0).
REQ-008 c_addr  in  ADDR_W  core word address.
REQ-009 c_wdata  in  DATA_W  core write data.
REQ-010 c_be  in  DATA_W/8  core byte enables.
REQ-011 c_gnt  out  1  core request accepted this cycle.
REQ-012 c_stall  out  1  c_req & ~c_gnt; freezes the core pipeline.
REQ-013 c_rvalid  out  1  core read data valid.
REQ-014 c_rdata  out  DATA_W  core read data.
REQ-015 d_req, d_we, d_addr, d_wdata, d_be  in  1/1/ADDR_W/DATA_W/DATA_W/8  debug/loader port, same meaning as core.
REQ-016 d_lock  in  1  debug requests exclusive ownership of the memory.
REQ-017 d_gnt, d_rvalid  out  1  debug accept and read-valid.
REQ-018 d_rdata  out  DATA_W  debug read data.
REQ-019 m_en, m_we  out  1  RAM enable and write enable.
REQ-020 m_addr, m_wdata, m_be  out  ADDR_W/DATA_W/DATA_W/8  RAM address, data and byte enables.
REQ-021 m_rdata  in  DATA_W  RAM read data, valid exactly one cycle after m_en & ~m_we.
REQ-022 locked  out  1  arbiter is in state LOCKED.

Function
REQ-023 FSM states SHALL be ARB and LOCKED.
REQ-024 In ARB, grant is combinational: core wins when c_req, unless starve_q; debug wins when d_req and (~c_req or starve_q).
REQ-025 At most one of c_gnt/d_gnt SHALL be high per cycle; the granted port's signals drive m_*, and m_en = c_gnt | d_gnt.
REQ-026 wait_cnt (3 bits, saturating) SHALL increment each cycle d_req is high and d_gnt is low, and clear on d_gnt.
REQ-027 starve_q SHALL set when wait_cnt reaches MAX_WAIT-1 with d_req still refused, and clear on the next d_gnt.
REQ-028 owner_q SHALL record the read owner (core/debug) when a read is granted; the next cycle asserts that port's rvalid with rdata = m_rdata.
REQ-029 The non-owner rdata SHALL hold 0. Writes SHALL produce no rvalid.
REQ-030 ARB -> LOCKED when d_gnt & d_lock.
REQ-031 In LOCKED, only debug is granted (d_gnt = d_req), c_gnt = 0, and wait_cnt and starve_q are held at 0.
REQ-032 LOCKED -> ARB on the first cycle d_lock is low; that cycle is already arbitrated as ARB.
REQ-033 A read granted on the cycle before an ownership change SHALL still return to its original owner.
REQ-034 A write followed by a read to the same address in the next cycle SHALL return the written data (RAM write-first ordering is owned by the RAM; the arbiter adds no reordering).
REQ-035 Latency: grant 0 cycles, read data 1 cycle after grant; throughput is one access per cycle.

Reset
REQ-036 While rst is high: state = ARB; wait_cnt, starve_q and owner_q are cleared; all gnt, rvalid, m_en and m_we outputs are 0; rdata outputs are 0.
REQ-037 Reset asserted mid-read SHALL suppress the pending rvalid.
REQ-038 rst dominates d_lock.

Verification
REQ-039 Core read addr 0x005 with RAM word 0xDEADBEEFCAFEBABE -> c_gnt the same cycle, c_rvalid the next cycle with that data, d_rvalid = 0.
REQ-040 c_req and d_req held high continuously, MAX_WAIT = 4 -> core granted 4 cycles, debug granted on the 5th, c_stall high on that cycle, then core granted again.
REQ-041 Debug with d_lock writes 0x7FF to addr 0x3FF over 3 cycles while c_req is high -> c_gnt = 0 and locked = 1 throughout; d_lock drops -> core granted the same cycle.
REQ-042 Debug read granted in cycle N, core granted in cycle N+1 -> d_rvalid in N+1 and c_rvalid in N+2 with correct per-port data.
REQ-043 rst asserted the cycle after a core read grant -> no c_rvalid, all outputs 0, state ARB after release.
REQ-044 Idle (no requests) -> m_en = 0 and wait_cnt stays 0 indefinitely.

Source files
------------

// File: rtl/mem_arbiter.sv
// Core/debug data-memory arbiter: core priority with debug anti-starvation and an exclusive debug lock.
// Grant in 0 cycles, read data 1 cycle after grant; the loser of a cycle sees gnt low (c_stall for the core).
module mem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                c_req,
   input  logic                c_we,
   input  logic [ADDR_W-1:0]   c_addr,
   input  logic [DATA_W-1:0]   c_wdata,
   input  logic [DATA_W/8-1:0] c_be,
   output logic                c_gnt,
   output logic                c_stall,
   output logic                c_rvalid,
   output logic [DATA_W-1:0]   c_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic                d_lock,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_en,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                locked
);

   typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [2:0] WAIT_LIM = 3'(MAX_WAIT - 1);

   state_t     state_q, state_d;
   logic [2:0] wait_cnt_q, wait_cnt_d;
   logic       starve_q, starve_d;
   logic       owner_q, owner_d;   // 1 = debug owns the pending read
   logic       rvalid_q, rvalid_d;
   logic       arb_mode;

   // A LOCKED cycle with d_lock low is already arbitrated normally.
   assign arb_mode = (state_q == ARB) | ~d_lock;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         wait_cnt_q <= 3'd0;
         starve_q   <= 1'b0;
         owner_q    <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         starve_q   <= starve_d;
         owner_q    <= owner_d;
         rvalid_q   <= rvalid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      starve_d   = starve_q;
      owner_d    = owner_q;
      rvalid_d   = m_en & ~m_we;
      if (m_en && !m_we) begin
         owner_d = d_gnt;
      end
      if (!arb_mode) begin
         state_d    = LOCKED;
         wait_cnt_d = 3'd0;
         starve_d   = 1'b0;
      end else begin
         state_d = (d_gnt && d_lock) ? LOCKED : ARB;
         if (d_gnt) begin
            wait_cnt_d = 3'd0;
            starve_d   = 1'b0;
         end else if (d_req) begin
            wait_cnt_d = (wait_cnt_q == 3'd7) ? 3'd7 : wait_cnt_q + 3'd1;
            if (wait_cnt_q == WAIT_LIM) begin
               starve_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      d_gnt = 1'b0;
      c_gnt = 1'b0;
      if (!rst) begin
         if (arb_mode) begin
            d_gnt = d_req & (~c_req | starve_q);
            c_gnt = c_req & ~d_gnt;
         end else begin
            d_gnt = d_req;
         end
      end
      c_stall  = c_req & ~c_gnt;
      m_en     = c_gnt | d_gnt;
      m_we     = (c_gnt & c_we) | (d_gnt & d_we);
      m_addr   = d_gnt ? d_addr  : c_addr;
      m_wdata  = d_gnt ? d_wdata : c_wdata;
      m_be     = d_gnt ? d_be    : c_be;
      c_rvalid = rvalid_q & ~owner_q & ~rst;
      d_rvalid = rvalid_q & owner_q & ~rst;
      c_rdata  = c_rvalid ? m_rdata : '0;
      d_rdata  = d_rvalid ? m_rdata : '0;
      locked   = (state_q == LOCKED) & ~rst;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and per-port read-data scoreboards.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_we, d_req, d_we, d_lock;
   logic [9:0]  c_addr, d_addr;
   logic [63:0] c_wdata, d_wdata;
   logic [7:0]  c_be, d_be;
   logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
   logic [63:0] c_rdata, d_rdata;
   logic        m_en, m_we, locked;
   logic [9:0]  m_addr;
   logic [63:0] m_wdata, m_rdata;
   logic [7:0]  m_be;
   logic        ram_init;

   logic [63:0] mem [0:1023];
   logic [63:0] cq[$];
   logic [63:0] dq[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_rdata(m_rdata), .locked(locked)
   );

   // Synchronous RAM, read data one cycle after the access.
   always @(posedge clk) begin
      if (ram_init) begin
         mem[10'h001] <= 64'h1111_2222_3333_4444;
         mem[10'h002] <= 64'h5555_6666_7777_8888;
         mem[10'h005] <= 64'hDEAD_BEEF_CAFE_BABE;
         mem[10'h3FF] <= 64'h0;
      end else if (m_en) begin
         if (m_we) begin
            for (int b = 0; b < 8; b++)
               if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
         end else begin
            m_rdata <= mem[m_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (c_rvalid === 1'b1) begin
         if (cq.size() == 0) chk("c_rvalid_unexpected", 64'd1, 64'd0);
         else chk("c_rdata", c_rdata, cq.pop_front());
         if (d_rvalid !== 1'b1) chk("d_rdata_idle_zero", d_rdata, 64'd0);
      end
      if (d_rvalid === 1'b1) begin
         if (dq.size() == 0) chk("d_rvalid_unexpected", 64'd1, 64'd0);
         else chk("d_rdata", d_rdata, dq.pop_front());
         if (c_rvalid !== 1'b1) chk("c_rdata_idle_zero", c_rdata, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [63:0] cd,
                        input logic dr, input logic dw, input logic [9:0] da, input logic [63:0] dd,
                        input logic dl);
      c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_be = 8'hFF;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_be = 8'hFF; d_lock = dl;
   endtask

   task automatic idle();
      drive(0, 0, 10'h0, 64'h0, 0, 0, 10'h0, 64'h0, 0);
   endtask

   initial begin
      rst = 1'b1;
      ram_init = 1'b1;
      m_rdata = 64'h0;
      drive(1, 0, 10'h005, 64'h0, 1, 0, 10'h002, 64'h0, 1);
      // Reset: requests and d_lock present, everything must stay quiet
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_c_gnt", c_gnt, 0);
         chk("rst_d_gnt", d_gnt, 0);
         chk("rst_m_en", m_en, 0);
         chk("rst_m_we", m_we, 0);
         chk("rst_locked", locked, 0);
         chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);
         chk("rst_rdata", c_rdata | d_rdata, 0);
         step();
      end
      rst = 1'b0;
      ram_init = 1'b0;
      idle();

      // Idle: no enable, wait counter stays clear
      for (int i = 0; i < 6; i++) begin
         step();
         idle();
         @(negedge clk);
         chk("idle_m_en", m_en, 0);
         chk("idle_wait_cnt", dut.wait_cnt_q, 0);
      end

      // Core read of 0x005
      step();
      drive(1, 0, 10'h005, 64'h0, 0, 0, 10'h0, 64'h0, 0);
      @(negedge clk);
      chk("c_read_gnt", c_gnt, 1);
      chk("c_read_m_addr", m_addr, 10'h005);
      chk("c_read_m_we", m_we, 0);
      cq.push_back(64'hDEAD_BEEF_CAFE_BABE);
      step();
      idle();
      @(negedge clk);
      chk("c_read_d_rvalid", d_rvalid, 0);
      chk("c_read_c_rvalid", c_rvalid, 1);

      // Contention: core 4 grants, debug on the 5th, then core again
      for (int i = 0; i < 6; i++) begin
         step();
         drive(1, 0, 10'h001, 64'h0, 1, 0, 10'h002, 64'h0, 0);
         @(negedge clk);
         chk("starve_c_gnt", c_gnt, (i == 4) ? 0 : 1);
         chk("starve_d_gnt", d_gnt, (i == 4) ? 1 : 0);
         chk("starve_c_stall", c_stall, (i == 4) ? 1 : 0);
         if (i == 4) dq.push_back(64'h5555_6666_7777_8888);
         else cq.push_back(64'h1111_2222_3333_4444);
      end
      step();
      idle();

      // Lock: debug writes 0x7FF to 0x3FF, core excluded while locked
      step();
      drive(0, 0, 10'h0, 64'h0, 1, 1, 10'h3FF, 64'h7FF, 1);
      @(negedge clk);
      chk("lock_entry_d_gnt", d_gnt, 1);
      chk("lock_entry_m_we", m_we, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         drive(1, 0, 10'h3FF, 64'h0, 1, 1, 10'h3FF, 64'h7FF, 1);
         @(negedge clk);
         chk("lock_c_gnt", c_gnt, 0);
         chk("lock_d_gnt", d_gnt, 1);
         chk("lock_locked", locked, 1);
         chk("lock_c_stall", c_stall, 1);
         chk("lock_m_wdata", m_wdata, 64'h7FF);
      end
      step();
      drive(1, 0, 10'h3FF, 64'h0, 0, 0, 10'h0, 64'h0, 0);
      @(negedge clk);
      chk("unlock_c_gnt", c_gnt, 1);
      cq.push_back(64'h7FF);
      step();
      idle();
      @(negedge clk);
      chk("unlock_locked", locked, 0);

      // Debug read in N, core read in N+1
      step();
      drive(0, 0, 10'h0, 64'h0, 1, 0, 10'h002, 64'h0, 0);
      @(negedge clk);
      chk("seq_d_gnt", d_gnt, 1);
      dq.push_back(64'h5555_6666_7777_8888);
      step();
      drive(1, 0, 10'h005, 64'h0, 0, 0, 10'h0, 64'h0, 0);
      @(negedge clk);
      chk("seq_c_gnt", c_gnt, 1);
      chk("seq_d_rvalid", d_rvalid, 1);
      chk("seq_c_rvalid_early", c_rvalid, 0);
      cq.push_back(64'hDEAD_BEEF_CAFE_BABE);
      step();
      idle();
      @(negedge clk);
      chk("seq_c_rvalid", c_rvalid, 1);

      // Reset right after a core read grant
      step();
      drive(1, 0, 10'h005, 64'h0, 0, 0, 10'h0, 64'h0, 0);
      @(negedge clk);
      chk("rstmid_c_gnt", c_gnt, 1);
      step();
      rst = 1'b1;
      idle();
      @(negedge clk);
      chk("rstmid_c_rvalid", c_rvalid, 0);
      chk("rstmid_c_rdata", c_rdata, 0);
      chk("rstmid_m_en", m_en, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_locked", locked, 0);
      chk("rstmid_rvalid", {c_rvalid, d_rvalid}, 0);
      step();
      drive(1, 0, 10'h001, 64'h0, 0, 0, 10'h0, 64'h0, 0);
      @(negedge clk);
      chk("post_rst_c_gnt", c_gnt, 1);
      cq.push_back(64'h1111_2222_3333_4444);
      step();
      idle();
      step();
      step();

      chk("cq_drained", cq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
